stack_ctrl: RTL

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl_pkg.sv | 26 ++
 rtl/stack_ptr.sv | 32 +++
 rtl/stack_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack controller: FSM encoding, default stack
// window and request decoding.
package stack_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_PUSH = 2'd1,
    CMD_POP  = 2'd2,
    CMD_BOTH = 2'd3
  } cmd_t;

  localparam logic [15:0] STK_BASE_DEF  = 16'hFFFF;
  localparam logic [15:0] STK_LIMIT_DEF = 16'hFF00;

  function automatic cmd_t decode_cmd(input logic push, input logic pop);
    return cmd_t'({pop, push});
  endfunction

endpackage

// File: rtl/stack_ptr.sv
// Stack pointer register. Increments/decrements are refused at the window
// edges so the pointer never leaves [LIMIT-1, BASE].
module stack_ptr
  import stack_ctrl_pkg::*;
#(
  parameter logic [15:0] BASE  = STK_BASE_DEF,
  parameter logic [15:0] LIMIT = STK_LIMIT_DEF
) (
  input  logic        SP_clk,
  input  logic        SP_rst_n,
  input  logic        SP_inc,
  input  logic        SP_dec,
  output logic [15:0] SP_val,
  output logic        SP_full,
  output logic        SP_empty
);

  localparam logic [15:0] FULL_VAL = LIMIT - 16'd1;

  assign SP_full  = (SP_val == FULL_VAL);
  assign SP_empty = (SP_val == BASE);

  always_ff @(posedge SP_clk or negedge SP_rst_n) begin
    if (!SP_rst_n)
      SP_val <= BASE;
    else if (SP_inc && !SP_dec && !SP_empty)
      SP_val <= SP_val + 16'd1;
    else if (SP_dec && !SP_inc && !SP_full)
      SP_val <= SP_val - 16'd1;
  end

endmodule

// File: rtl/stack_ctrl.sv
// Empty-descending hardware stack controller: accepts push/pop in IDLE,
// runs one req/ack memory access, then pulses done for a cycle.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter logic [15:0] STK_BASE  = STK_BASE_DEF,
  parameter logic [15:0] STK_LIMIT = STK_LIMIT_DEF
) (
  input  logic        STK_clk,
  input  logic        STK_rst_n,
  input  logic        STK_push,
  input  logic        STK_pop,
  input  logic [15:0] STK_din,
  output logic [15:0] STK_dout,
  output logic        STK_done,
  output logic        STK_err,
  output logic        STK_busy,
  output logic [15:0] STK_sp,
  output logic        STK_mem_req,
  output logic        STK_mem_we,
  output logic [15:0] STK_mem_addr,
  output logic [15:0] STK_mem_wdata,
  input  logic        STK_mem_ack,
  input  logic [15:0] STK_mem_rdata
);

  state_t state, state_nxt;
  cmd_t   cmd;
  logic   sp_inc, sp_dec, sp_full, sp_empty;
  logic   acc_push, acc_pop, reject;

  stack_ptr #(
    .BASE (STK_BASE),
    .LIMIT(STK_LIMIT)
  ) u_sp (
    .SP_clk  (STK_clk),
    .SP_rst_n(STK_rst_n),
    .SP_inc  (sp_inc),
    .SP_dec  (sp_dec),
    .SP_val  (STK_sp),
    .SP_full (sp_full),
    .SP_empty(sp_empty)
  );

  assign cmd = decode_cmd(STK_push, STK_pop);

  always_comb begin
    state_nxt = state;
    acc_push  = 1'b0;
    acc_pop   = 1'b0;
    reject    = 1'b0;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    case (state)
      IDLE: begin
        case (cmd)
          CMD_PUSH: begin
            if (sp_full) reject = 1'b1;
            else begin
              acc_push  = 1'b1;
              state_nxt = WRITE;
            end
          end
          CMD_POP: begin
            if (sp_empty) reject = 1'b1;
            else begin
              acc_pop   = 1'b1;
              state_nxt = READ;
            end
          end
          CMD_BOTH: reject = 1'b1;
          default: ;
        endcase
      end
      // Pointer moves only once memory confirms the access.
      WRITE: if (STK_mem_ack) begin
        sp_dec    = 1'b1;
        state_nxt = DONE;
      end
      READ: if (STK_mem_ack) begin
        sp_inc    = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge STK_clk or negedge STK_rst_n) begin
    if (!STK_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Access attributes are latched at acceptance so they stay stable under req.
  always_ff @(posedge STK_clk or negedge STK_rst_n) begin
    if (!STK_rst_n) begin
      STK_mem_addr  <= '0;
      STK_mem_wdata <= '0;
      STK_mem_we    <= 1'b0;
      STK_dout      <= '0;
      STK_err       <= 1'b0;
    end else begin
      STK_err <= reject;
      if (acc_push) begin
        STK_mem_addr  <= STK_sp;
        STK_mem_wdata <= STK_din;
        STK_mem_we    <= 1'b1;
      end else if (acc_pop) begin
        STK_mem_addr <= STK_sp + 16'd1;
        STK_mem_we   <= 1'b0;
      end
      if (state == READ && STK_mem_ack)
        STK_dout <= STK_mem_rdata;
    end
  end

  assign STK_mem_req = (state == WRITE) || (state == READ);
  assign STK_done    = (state == DONE);
  assign STK_busy    = (state != IDLE);

endmodule
